cp0_ctrl_gen2: RTL and testbench
================================

Name: cp0_ctrl_gen2

Overview:
Second-generation coprocessor-0 for the pipelined MIPS core. It sits beside the M stage and owns SR, Cause, EPC and PRID. It adds a Count/Compare timer with a prescaler, two software-interrupt bits, and a parametrised number of hardware interrupt lines. It raises int_req to flush the pipeline and redirect to the handler, and supplies epc for eret.

Parameters:
N_HWINT, 6, number of hardware interrupt lines (legal 1..6)
TIMER_LINE, 5, hardware line the timer ORs into; a value >= N_HWINT means the timer never interrupts
COUNT_DIV, 1, Count increments once every COUNT_DIV clocks (legal >= 1)
RESET_EPC, 32'h0000_3000, EPC value after reset
PRID_VALUE, 32'h6666_7777, read-only PRID contents

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
we  in  1  mtc0 write enable
exl_clr  in  1  eret in M stage
rd_addr  in  5  mfc0 register number
wr_addr  in  5  mtc0 register number
din  in  32  mtc0 data
m_pc  in  32  PC of the M-stage instruction
m_bd  in  1  M-stage instruction is in a delay slot
m_exc_code  in  5  M-stage exception code; 31 = none
hw_int  in  N_HWINT  level-sensitive device interrupts
int_req  out  1  take interrupt/exception this cycle (combinational)
epc  out  32  current EPC
dout  out  32  mfc0 read data (combinational)
timer_irq  out  1  registered TI flag

Behaviour:
- Register map: 9 Count, 11 Compare, 12 SR, 13 Cause, 14 EPC, 15 PRID (read-only, writes ignored). Unmapped reads return 0.
- SR layout: [10+N_HWINT-1:10] IM_hw, [9:8] IM_sw, [1] EXL, [0] IE. All other bits read 0.
- Cause layout: [31] BD, [30] TI, [10+N_HWINT-1:10] IP_hw (live), [9:8] IP_sw (writable), [6:2] ExcCode.
- pending = {IP_hw | (TI on TIMER_LINE), IP_sw}. IP_hw is hw_int registered every cycle.
- int_cond = IE & ~EXL & |(IM & pending), using the registered IP_hw.
- exc_cond = (m_exc_code != 31) & ~EXL & ~int_cond.
- int_req = int_cond | exc_cond. Forced 0 while reset_n is low.
- Reset (async) values:
  - IM all ones, IE=1, EXL=0, BD=0, ExcCode=0, IP_sw=0
  - EPC=RESET_EPC, Count=0, Compare=32'hFFFF_FFFF, TI=0, prescaler=0
  - epc=RESET_EPC, timer_irq=0
- Update priority per clock edge: exl_clr > int_cond > exc_cond > we.
  - exl_clr: EXL<=0.
  - int_cond: EXL<=1, BD<=m_bd, ExcCode<=0, EPC<=m_bd ? m_pc-4 : m_pc.
  - exc_cond: same as int_cond but ExcCode<=m_exc_code.
  - we: write the addressed register fields.
    - EPC writes store din with bits [1:0] cleared.
    - Cause writes update only BD, IP_sw and ExcCode.
- Timer:
  - Prescaler counts 0..COUNT_DIV-1; Count increments (wrapping 32'hFFFF_FFFF -> 0) when the prescaler wraps.
  - TI<=1 on the edge where the new Count equals Compare.
  - A Compare write clears TI and prescaler is unaffected.
  - A Count write loads din and resets the prescaler. In that cycle the write wins over the increment, and no match is evaluated.
- Timer updates run every cycle, independent of exl_clr, int_cond and exc_cond. A Count/Compare write is suppressed when int_cond or exc_cond fires, because the M-stage mtc0 is squashed.
- dout forwarding: if we & (rd_addr == wr_addr) & (wr_addr != 15), dout=din; otherwise the register view.
- Reset mid-operation restores all state immediately, including the prescaler.

Decomposition:
- Package cp0_pkg holds:
  - register-number constants (CP0_COUNT=9, CP0_COMPARE=11, CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15)
  - ExcCode constants (EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12, EXC_NONE=31)
- One sub-module, cp0_timer, owns the prescaler, Count, Compare, TI and match logic. It takes write strobes and a squash input.

Test Plan:
- Reset then mfc0 12 -> dout = 32'h0000_FF01 (N_HWINT=6); mfc0 14 -> 32'h0000_3000; int_req=0.
- hw_int=6'b000100 with IE=1, EXL=0 -> int_req=1 one cycle after hw_int (registered IP); with m_pc=32'h3010, m_bd=1 -> EPC=32'h300C, ExcCode=0, EXL=1; further hw_int and exceptions give int_req=0 until exl_clr.
- m_exc_code=12 with hw_int asserted and IM masked -> ExcCode=12. With IM unmasked in the same cycle -> ExcCode=0 (interrupt wins).
- COUNT_DIV=4: write Count=10, Compare=12 -> TI=1 exactly 8 clocks after the Count write and Cause[30]=1; int_req=1 only if IM[TIMER_LINE]=1. Writing Compare clears TI.
- Write Cause IP_sw=2'b01 with IM_sw[0]=1, IE=1 -> int_req=1 on the next cycle. we & rd_addr==wr_addr==13 -> dout=din same cycle.
- Count=32'hFFFF_FFFF, Compare=0, COUNT_DIV=1 -> wraps to 0 and TI=1. Assert reset_n low mid-count -> Count=0 and TI=0 asynchronously.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers and exception codes.
package cp0_pkg;

   localparam logic [4:0] CP0_COUNT   = 5'd9;
   localparam logic [4:0] CP0_COMPARE = 5'd11;
   localparam logic [4:0] CP0_SR      = 5'd12;
   localparam logic [4:0] CP0_CAUSE   = 5'd13;
   localparam logic [4:0] CP0_EPC     = 5'd14;
   localparam logic [4:0] CP0_PRID    = 5'd15;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;
   localparam logic [4:0] EXC_NONE = 5'd31;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with prescaler; raises TI when an incremented Count hits Compare.
module cp0_timer #(
   parameter int unsigned COUNT_DIV = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic        squash,
   input  logic [31:0] din,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti
);

   localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [31:0]   count_q, count_d, compare_q, compare_d;
   logic          ti_q, ti_d;
   logic          count_wr, compare_wr, inc;

   assign count_wr   = count_we & ~squash;
   assign compare_wr = compare_we & ~squash;

   always_comb begin
      presc_d   = presc_q;
      count_d   = count_q;
      compare_d = compare_q;
      ti_d      = ti_q;
      inc       = 1'b0;
      if (count_wr) begin
         // A loaded Count restarts the prescaler and skips the match check
         count_d = din;
         presc_d = '0;
      end else if (presc_q == PRESC_MAX) begin
         presc_d = '0;
         count_d = count_q + 32'd1;
         inc     = 1'b1;
      end else begin
         presc_d = presc_q + PW'(1);
      end
      if (inc && (count_d == compare_q)) ti_d = 1'b1;
      if (compare_wr) begin
         compare_d = din;
         ti_d      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q   <= '0;
         count_q   <= '0;
         compare_q <= 32'hFFFF_FFFF;
         ti_q      <= 1'b0;
      end else begin
         presc_q   <= presc_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         ti_q      <= ti_d;
      end
   end

   assign count   = count_q;
   assign compare = compare_q;
   assign ti      = ti_q;

endmodule

// File: rtl/cp0_ctrl_gen2.sv
// Coprocessor 0 beside the M stage: SR/Cause/EPC/PRID, interrupt and exception entry,
// and the Count/Compare timer.
module cp0_ctrl_gen2 #(
   parameter int unsigned N_HWINT    = 6,
   parameter int unsigned TIMER_LINE = 5,
   parameter int unsigned COUNT_DIV  = 1,
   parameter logic [31:0] RESET_EPC  = 32'h0000_3000,
   parameter logic [31:0] PRID_VALUE = 32'h6666_7777
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               we,
   input  logic               exl_clr,
   input  logic [4:0]         rd_addr,
   input  logic [4:0]         wr_addr,
   input  logic [31:0]        din,
   input  logic [31:0]        m_pc,
   input  logic               m_bd,
   input  logic [4:0]         m_exc_code,
   input  logic [N_HWINT-1:0] hw_int,
   output logic               int_req,
   output logic [31:0]        epc,
   output logic [31:0]        dout,
   output logic               timer_irq
);

   import cp0_pkg::*;

   logic [N_HWINT-1:0] im_hw_q, ip_hw_q, hw_pend;
   logic [1:0]         im_sw_q, ip_sw_q;
   logic               ie_q, exl_q, bd_q;
   logic [4:0]         exc_code_q;
   logic [31:0]        epc_q, count, compare, sr_view, cause_view;
   logic               ti, int_cond, exc_cond;

   always_comb begin
      for (int unsigned i = 0; i < N_HWINT; i++) begin
         hw_pend[i] = ip_hw_q[i] | (ti && (i == TIMER_LINE));
      end
   end

   assign int_cond = ie_q & ~exl_q & (|({im_hw_q, im_sw_q} & {hw_pend, ip_sw_q}));
   assign exc_cond = (m_exc_code != EXC_NONE) & ~exl_q & ~int_cond;
   assign int_req  = reset_n & (int_cond | exc_cond);

   cp0_timer #(
      .COUNT_DIV (COUNT_DIV)
   ) u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .count_we   (we && (wr_addr == CP0_COUNT)),
      .compare_we (we && (wr_addr == CP0_COMPARE)),
      .squash     (int_cond | exc_cond),
      .din        (din),
      .count      (count),
      .compare    (compare),
      .ti         (ti)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         im_hw_q    <= '1;
         im_sw_q    <= '1;
         ie_q       <= 1'b1;
         exl_q      <= 1'b0;
         bd_q       <= 1'b0;
         exc_code_q <= EXC_INT;
         ip_sw_q    <= '0;
         ip_hw_q    <= '0;
         epc_q      <= RESET_EPC;
      end else begin
         ip_hw_q <= hw_int;
         if (exl_clr) begin
            exl_q <= 1'b0;
         end else if (int_cond || exc_cond) begin
            exl_q      <= 1'b1;
            bd_q       <= m_bd;
            exc_code_q <= int_cond ? EXC_INT : m_exc_code;
            epc_q      <= m_bd ? (m_pc - 32'd4) : m_pc;
         end else if (we) begin
            case (wr_addr)
               CP0_SR: begin
                  im_hw_q <= din[10 +: N_HWINT];
                  im_sw_q <= din[9:8];
                  exl_q   <= din[1];
                  ie_q    <= din[0];
               end
               CP0_CAUSE: begin
                  bd_q       <= din[31];
                  ip_sw_q    <= din[9:8];
                  exc_code_q <= din[6:2];
               end
               CP0_EPC: epc_q <= {din[31:2], 2'b00};
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      sr_view                   = '0;
      sr_view[10 +: N_HWINT]    = im_hw_q;
      sr_view[9:8]              = im_sw_q;
      sr_view[1]                = exl_q;
      sr_view[0]                = ie_q;
      cause_view                = '0;
      cause_view[31]            = bd_q;
      cause_view[30]            = ti;
      cause_view[10 +: N_HWINT] = ip_hw_q;
      cause_view[9:8]           = ip_sw_q;
      cause_view[6:2]           = exc_code_q;
   end

   always_comb begin
      dout = '0;
      // mtc0 to the same register in this cycle is forwarded to mfc0
      if (we && (rd_addr == wr_addr) && (wr_addr != CP0_PRID)) begin
         dout = din;
      end else begin
         case (rd_addr)
            CP0_COUNT:   dout = count;
            CP0_COMPARE: dout = compare;
            CP0_SR:      dout = sr_view;
            CP0_CAUSE:   dout = cause_view;
            CP0_EPC:     dout = epc_q;
            CP0_PRID:    dout = PRID_VALUE;
            default:     dout = '0;
         endcase
      end
   end

   assign epc       = epc_q;
   assign timer_irq = ti;

endmodule

// File: tb/tb_cp0_ctrl_gen2.sv
// Directed bench for cp0_ctrl_gen2: one instance with COUNT_DIV=4, one with COUNT_DIV=1.
module tb_cp0_ctrl_gen2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        we, exl_clr, m_bd;
   logic [4:0]  rd_addr, wr_addr, m_exc_code;
   logic [31:0] din, m_pc;
   logic [5:0]  hw_int;
   logic        int_req, timer_irq, int_req1, timer_irq1;
   logic [31:0] epc, dout, epc1, dout1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cp0_ctrl_gen2 #(
      .N_HWINT    (6),
      .TIMER_LINE (5),
      .COUNT_DIV  (4),
      .RESET_EPC  (32'h0000_3000),
      .PRID_VALUE (32'h6666_7777)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .we         (we),
      .exl_clr    (exl_clr),
      .rd_addr    (rd_addr),
      .wr_addr    (wr_addr),
      .din        (din),
      .m_pc       (m_pc),
      .m_bd       (m_bd),
      .m_exc_code (m_exc_code),
      .hw_int     (hw_int),
      .int_req    (int_req),
      .epc        (epc),
      .dout       (dout),
      .timer_irq  (timer_irq)
   );

   cp0_ctrl_gen2 #(
      .N_HWINT    (6),
      .TIMER_LINE (5),
      .COUNT_DIV  (1),
      .RESET_EPC  (32'h0000_3000),
      .PRID_VALUE (32'h6666_7777)
   ) dut1 (
      .clk        (clk),
      .reset_n    (reset_n),
      .we         (we),
      .exl_clr    (exl_clr),
      .rd_addr    (rd_addr),
      .wr_addr    (wr_addr),
      .din        (din),
      .m_pc       (m_pc),
      .m_bd       (m_bd),
      .m_exc_code (m_exc_code),
      .hw_int     (hw_int),
      .int_req    (int_req1),
      .epc        (epc1),
      .dout       (dout1),
      .timer_irq  (timer_irq1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      we = 1'b1; wr_addr = a; din = d;
   endtask

   initial begin
      reset_n = 1'b0; we = 1'b0; exl_clr = 1'b0; m_bd = 1'b0;
      rd_addr = 5'd0; wr_addr = 5'd0; din = '0; m_pc = '0;
      m_exc_code = 5'd31; hw_int = '0;
      #1;
      check("int_req_in_reset", {31'd0, int_req}, 32'd0);
      step(); step();
      reset_n = 1'b1;

      // Reset view
      rd_addr = 5'd12; #1;
      check("sr_reset", dout, 32'h0000_FF01);
      rd_addr = 5'd14; #1;
      check("epc_reset", dout, 32'h0000_3000);
      check("int_req_reset", {31'd0, int_req}, 32'd0);
      rd_addr = 5'd15; #1;
      check("prid", dout, 32'h6666_7777);

      // Hardware interrupt, delay slot
      hw_int = 6'b000100; m_pc = 32'h0000_3010; m_bd = 1'b1; #1;
      check("int_req_before_reg", {31'd0, int_req}, 32'd0);
      step();
      check("int_req_hw", {31'd0, int_req}, 32'd1);
      step();
      check("int_req_after_exl", {31'd0, int_req}, 32'd0);
      check("epc_bd", epc, 32'h0000_300C);
      rd_addr = 5'd13; #1;
      check("cause_hw", dout, 32'h8000_1000);
      rd_addr = 5'd12; #1;
      check("sr_exl", dout, 32'h0000_FF03);
      m_exc_code = 5'd12; #1;
      check("exc_blocked_exl", {31'd0, int_req}, 32'd0);
      m_exc_code = 5'd31; hw_int = '0; exl_clr = 1'b1;
      step();
      exl_clr = 1'b0; #1;
      check("sr_exl_clr", dout, 32'h0000_FF01);
      check("int_req_idle", {31'd0, int_req}, 32'd0);

      // Exception with hw interrupt masked
      wr(5'd12, 32'h0000_0301); #1;
      check("sr_forward", dout, 32'h0000_0301);
      step();
      we = 1'b0; hw_int = 6'b000100; m_exc_code = 5'd12; m_pc = 32'h0000_4000; m_bd = 1'b0; #1;
      check("int_req_exc", {31'd0, int_req}, 32'd1);
      step();
      m_exc_code = 5'd31; rd_addr = 5'd13; #1;
      check("cause_exc", dout, 32'h0000_1030);
      check("epc_exc", epc, 32'h0000_4000);
      exl_clr = 1'b1;
      step();
      exl_clr = 1'b0;
      wr(5'd12, 32'h0000_FF01);
      step();
      we = 1'b0; m_exc_code = 5'd12; #1;
      check("int_req_int_wins", {31'd0, int_req}, 32'd1);
      step();
      m_exc_code = 5'd31; #1;
      check("cause_int_wins", dout, 32'h0000_1000);
      hw_int = '0; exl_clr = 1'b1;
      step();
      exl_clr = 1'b0;

      // Timer, COUNT_DIV=4, timer line masked
      wr(5'd12, 32'h0000_0001);
      step();
      wr(5'd11, 32'd12);
      step();
      wr(5'd9, 32'd10);
      step();
      we = 1'b0; rd_addr = 5'd9; #1;
      check("count_loaded", dout, 32'd10);
      for (int i = 0; i < 7; i++) step();
      check("ti_early", {31'd0, timer_irq}, 32'd0);
      step();
      check("ti_set", {31'd0, timer_irq}, 32'd1);
      rd_addr = 5'd13; #1;
      check("cause_ti", dout, 32'h4000_0000);
      check("int_req_ti_masked", {31'd0, int_req}, 32'd0);
      rd_addr = 5'd12;
      wr(5'd12, 32'h0000_8001); #1;
      check("sr_forward_im5", dout, 32'h0000_8001);
      step();
      we = 1'b0; #1;
      check("int_req_ti", {31'd0, int_req}, 32'd1);
      wr(5'd11, 32'h0000_0100);
      step();
      we = 1'b0; #1;
      check("ti_squashed_write", {31'd0, timer_irq}, 32'd1);
      wr(5'd11, 32'h0000_0100);
      step();
      we = 1'b0; #1;
      check("ti_cleared", {31'd0, timer_irq}, 32'd0);
      exl_clr = 1'b1;
      step();
      exl_clr = 1'b0;

      // Software interrupt
      wr(5'd12, 32'h0000_0101);
      step();
      rd_addr = 5'd13;
      wr(5'd13, 32'h0000_0100); #1;
      check("cause_forward", dout, 32'h0000_0100);
      step();
      we = 1'b0; #1;
      check("int_req_sw", {31'd0, int_req}, 32'd1);
      step();
      wr(5'd13, 32'h0000_0000);
      step();
      we = 1'b0; exl_clr = 1'b1;
      step();
      exl_clr = 1'b0; #1;
      check("int_req_sw_done", {31'd0, int_req}, 32'd0);

      // Count wrap on the COUNT_DIV=1 instance, then async reset
      wr(5'd11, 32'h0000_0000);
      step();
      wr(5'd9, 32'hFFFF_FFFF);
      step();
      we = 1'b0; rd_addr = 5'd9; #1;
      check("count1_max", dout1, 32'hFFFF_FFFF);
      step();
      check("count1_wrap", dout1, 32'd0);
      check("ti1_wrap", {31'd0, timer_irq1}, 32'd1);
      step(); step(); step();
      check("count1_run", dout1, 32'd3);
      #2 reset_n = 1'b0;
      #1;
      check("count1_async_reset", dout1, 32'd0);
      check("ti1_async_reset", {31'd0, timer_irq1}, 32'd0);
      check("int_req_async_reset", {31'd0, int_req}, 32'd0);
      check("epc_async_reset", epc, 32'h0000_3000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
